full_adder_unit: RTL and testbench
==================================

Name: full_adder_unit

Overview:
- Registered full adder: adds operands a and b plus carry-in c, producing sum and carry-out one clock after a valid input.
- Default configuration is a single-bit adder cell.
- Parameter WIDTH turns it into a ripple-carry vector adder.
- Used as a leaf arithmetic primitive in datapaths that need a clocked, reset-clean adder stage.

Parameters:
- WIDTH, 1, operand width in bits; must be at least 1. c is always 1 bit and enters at bit 0.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in_valid  input  1  a, b and c are sampled on the clk rising edge when high.
- a  input  WIDTH  addend A, unsigned.
- b  input  WIDTH  addend B, unsigned.
- c  input  1  carry-in.
- sum  output  WIDTH  registered sum, equal to (a + b + c) mod 2^WIDTH.
- carry  output  1  registered carry-out of the MSB.
- out_valid  output  1  high for one cycle when sum and carry hold a new result.

Behaviour:
- Reset: while rst_n is low, sum = 0, carry = 0, out_valid = 0, regardless of clk. Reset is removed synchronously by the first clk edge after rst_n rises.
- Bit cell for bit i: s_i = a_i ^ b_i ^ k_i; k_(i+1) = (a_i & b_i) | (a_i & k_i) | (b_i & k_i); k_0 = c; carry = k_WIDTH.
- Arithmetic: {carry, sum} = a + b + c, computed at WIDTH+1 bits with no truncation of the carry.
- Latency: 1 cycle. On a rising edge with in_valid = 1, sum and carry load the combinational result and out_valid is set to 1.
- On a rising edge with in_valid = 0: sum and carry hold their previous values and out_valid goes to 0.
- Back-to-back valid inputs give one result per cycle, with out_valid staying high. There is no backpressure.
- Inputs changing between edges have no effect on the outputs. No combinational path runs from any input to any output.
- Reset asserted mid-stream clears the outputs immediately. The pending sample is discarded.
- All-ones case: WIDTH = 1 with a = b = c = 1 gives sum = 1, carry = 1. For any WIDTH, a = b = all-ones with c = 1 gives sum = all-ones, carry = 1.
- Zero case: a = b = c = 0 gives sum = 0, carry = 0.
- X or Z on inputs while in_valid = 0 must not propagate to the outputs.

Optional Feature:
- Macro: FULL_ADDER_UNIT_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit, registered, reset value 0).
  - ovf = k_WIDTH ^ k_(WIDTH-1), i.e. signed two's-complement overflow.
  - ovf is loaded and held under the same in_valid rules as sum and carry.
  - For WIDTH = 1, ovf = carry ^ c.
- When not defined: the port is absent and no overflow logic exists.

Decomposition:
- Package full_adder_pkg holds:
  - constant FA_SUM_RST = 0;
  - constant FA_CARRY_RST = 0;
  - a function fa_bit_fn(a, b, cin) returning {cout, s}, used by the RTL and the bench model.
- Sub-module fa_cell: one purely combinational 1-bit full adder with ports a, b, cin, s, cout.
  - Instanced WIDTH times in a generate loop and chained through the k_i carry signals.
- The top-level module contains only the carry chain and the output registers.

Test Plan:
- WIDTH = 1, in_valid = 1, apply (a, b, c) in this order, expecting each result one clk later:
  - 0,0,0 -> sum 0, carry 0.
  - 0,1,0 -> sum 1, carry 0.
  - 1,0,1 -> sum 0, carry 1.
  - 1,1,1 -> sum 1, carry 1.
  - 1,1,0 -> sum 0, carry 1.
  - 1,0,1 -> sum 0, carry 1.
  - out_valid stays high throughout.
- Exhaustive WIDTH = 1: all 8 input combinations, each compared against fa_bit_fn.
- Hold: load 1,1,1 -> sum 1, carry 1. Then drop in_valid and toggle the inputs for 3 cycles. Outputs stay 1,1 and out_valid = 0.
- Reset: load 1,1,1, then pulse rst_n low between clock edges. sum, carry and out_valid go to 0 immediately, before the next edge. After release, the first valid 0,1,0 -> 1,0.
- WIDTH = 4:
  - a = 4'hF, b = 4'hF, c = 1 -> sum 4'hF, carry 1.
  - a = 4'h7, b = 4'h1, c = 0 -> sum 4'h8, carry 0, ovf 1 (with FULL_ADDER_UNIT_OVF_EN).
- Random: 1000 valid/invalid mixed cycles at WIDTH = 8. Check {carry, sum} == a + b + c one cycle after each valid input, and check that out_valid matches in_valid delayed by one cycle.

Source files
------------

// File: rtl/full_adder_pkg.sv
// Shared constants and the 1-bit full-adder function for the registered adder.
// Used by fa_cell, full_adder_unit and the testbench reference model.
package full_adder_pkg;

  localparam logic FA_SUM_RST   = 1'b0;
  localparam logic FA_CARRY_RST = 1'b0;

  // Returns {cout, s} for one bit position.
  function automatic logic [1:0] fa_bit_fn(input logic a, input logic b, input logic cin);
    return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Purely combinational 1-bit full adder cell; one link of the ripple-carry chain.
module fa_cell
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign {cout, s} = fa_bit_fn(a, b, cin);

endmodule

// File: rtl/full_adder_unit.sv
// Registered ripple-carry adder: {carry, sum} = a + b + c, one cycle after in_valid.
// Define FULL_ADDER_UNIT_OVF_EN to add the registered signed-overflow output ovf.
module full_adder_unit
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
`ifdef FULL_ADDER_UNIT_OVF_EN
  ,
  output logic             ovf
`endif
);

  // k[i] is the carry into bit i; k[0] is the external carry-in.
  logic [WIDTH:0]   k;
  logic [WIDTH-1:0] s_comb;

  assign k[0] = c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (k[i]),
      .s    (s_comb[i]),
      .cout (k[i+1])
    );
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= {WIDTH{FA_SUM_RST}};
      carry     <= FA_CARRY_RST;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= s_comb;
        carry <= k[WIDTH];
      end
    end
  end

`ifdef FULL_ADDER_UNIT_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= k[WIDTH] ^ k[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_full_adder_unit.sv
// Self-checking bench for full_adder_unit at WIDTH = 1, 4 and 8 with a scoreboard per instance.
// Checks ovf as well when FULL_ADDER_UNIT_OVF_EN is defined.
module tb_full_adder_unit;
  import full_adder_pkg::*;

  typedef struct packed {
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       v1, a1, b1, c1, s1, k1, ov1;
  logic       v4, c4, k4, ov4;
  logic [3:0] a4, b4, s4;
  logic       v8, c8, k8, ov8;
  logic [7:0] a8, b8, s8;
`ifdef FULL_ADDER_UNIT_OVF_EN
  logic       f1, f4, f8;
`endif

  full_adder_unit #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .c(c1),
    .sum(s1), .carry(k1), .out_valid(ov1)
`ifdef FULL_ADDER_UNIT_OVF_EN
    , .ovf(f1)
`endif
  );

  full_adder_unit #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .c(c4),
    .sum(s4), .carry(k4), .out_valid(ov4)
`ifdef FULL_ADDER_UNIT_OVF_EN
    , .ovf(f4)
`endif
  );

  full_adder_unit #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .c(c8),
    .sum(s8), .carry(k8), .out_valid(ov8)
`ifdef FULL_ADDER_UNIT_OVF_EN
    , .ovf(f8)
`endif
  );

  exp_t q1[$], q4[$], q8[$];
  exp_t last_exp[3];
  int   checks   = 0;
  int   failures = 0;

  // Expected {carry, sum, ovf} from independent arithmetic; WIDTH=1 uses fa_bit_fn.
  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                 input logic c);
    exp_t       e;
    logic [8:0] t;
    logic [7:0] m;
    logic [1:0] r;
    m = 8'((9'd1 << w) - 9'd1);
    e = '0;
    if (w == 1) begin
      r        = fa_bit_fn(a[0], b[0], c);
      e.sum[0] = r[0];
      e.carry  = r[1];
    end else begin
      t       = {1'b0, a & m} + {1'b0, b & m} + {8'd0, c};
      e.sum   = t[7:0] & m;
      e.carry = t[w];
    end
    e.ovf = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
    return e;
  endfunction

  function automatic exp_t observe(input int idx);
    exp_t g;
    g = '0;
    case (idx)
      0: begin g.sum = {7'd0, s1}; g.carry = k1;
`ifdef FULL_ADDER_UNIT_OVF_EN
        g.ovf = f1;
`endif
      end
      1: begin g.sum = {4'd0, s4}; g.carry = k4;
`ifdef FULL_ADDER_UNIT_OVF_EN
        g.ovf = f4;
`endif
      end
      default: begin g.sum = s8; g.carry = k8;
`ifdef FULL_ADDER_UNIT_OVF_EN
        g.ovf = f8;
`endif
      end
    endcase
    return g;
  endfunction

  // Drive one cycle on instance idx (0:W1, 1:W4, 2:W8), then check one cycle later.
  task automatic step(input int idx, input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic v, input string name);
    exp_t e, g;
    logic ov;
    int   w;
    int   qn;
    w = (idx == 0) ? 1 : (idx == 1) ? 4 : 8;
    case (idx)
      0:       begin v1 = v; a1 = a[0];   b1 = b[0];   c1 = c; end
      1:       begin v4 = v; a4 = a[3:0]; b4 = b[3:0]; c4 = c; end
      default: begin v8 = v; a8 = a;      b8 = b;      c8 = c; end
    endcase
    if (v) begin
      e = model(w, a, b, c);
      case (idx)
        0:       q1.push_back(e);
        1:       q4.push_back(e);
        default: q8.push_back(e);
      endcase
    end
    @(posedge clk);
    #1;
    ov = (idx == 0) ? ov1 : (idx == 1) ? ov4 : ov8;
    checks++;
    if (ov !== v) begin
      failures++;
      $display("FAIL %s out_valid w=%0d got=%b exp=%b", name, w, ov, v);
    end
    if (ov === 1'b1) begin
      qn = (idx == 0) ? q1.size() : (idx == 1) ? q4.size() : q8.size();
      if (qn == 0) begin
        checks++;
        failures++;
        $display("FAIL %s spurious out_valid w=%0d", name, w);
      end else begin
        case (idx)
          0:       last_exp[0] = q1.pop_front();
          1:       last_exp[1] = q4.pop_front();
          default: last_exp[2] = q8.pop_front();
        endcase
      end
    end
    g = observe(idx);
    checks++;
    if (g.sum !== last_exp[idx].sum || g.carry !== last_exp[idx].carry) begin
      failures++;
      $display("FAIL %s w=%0d a=%h b=%h c=%b got carry=%b sum=%h exp carry=%b sum=%h",
               name, w, a, b, c, g.carry, g.sum, last_exp[idx].carry, last_exp[idx].sum);
    end
`ifdef FULL_ADDER_UNIT_OVF_EN
    checks++;
    if (g.ovf !== last_exp[idx].ovf) begin
      failures++;
      $display("FAIL %s ovf w=%0d got=%b exp=%b", name, w, g.ovf, last_exp[idx].ovf);
    end
`endif
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < 3; i++) begin
      exp_t g;
      logic ov;
      g  = observe(i);
      ov = (i == 0) ? ov1 : (i == 1) ? ov4 : ov8;
      checks++;
      if (g !== '0 || ov !== 1'b0) begin
        failures++;
        $display("FAIL %s inst=%0d got carry=%b sum=%h ovf=%b out_valid=%b exp all 0",
                 name, i, g.carry, g.sum, g.ovf, ov);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    v1 = 0; a1 = 0; b1 = 0; c1 = 0;
    v4 = 0; a4 = 0; b4 = 0; c4 = 0;
    v8 = 0; a8 = 0; b8 = 0; c8 = 0;
    for (int i = 0; i < 3; i++) last_exp[i] = '0;
    #2;
    check_all_zero("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_sequence_w1();
    logic [2:0] vec [6] = '{3'b000, 3'b010, 3'b101, 3'b111, 3'b110, 3'b101};
    for (int i = 0; i < 6; i++) begin
      logic [2:0] t;
      t = vec[i];
      step(0, {7'd0, t[2]}, {7'd0, t[1]}, t[0], 1'b1, "seq_w1");
    end
  endtask

  task automatic test_exhaustive_w1();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] t;
      t = 3'(i);
      step(0, {7'd0, t[2]}, {7'd0, t[1]}, t[0], 1'b1, "exh_w1");
    end
  endtask

  task automatic test_hold();
    step(0, 8'd1, 8'd1, 1'b1, 1'b1, "hold_load");
    step(0, 8'd0, 8'd0, 1'b0, 1'b0, "hold_toggle");
    step(0, 8'd1, 8'd0, 1'b1, 1'b0, "hold_toggle");
    step(0, 8'hxx, 8'hzz, 1'bx, 1'b0, "hold_xz");
  endtask

  task automatic test_reset_midstream();
    step(0, 8'd1, 8'd1, 1'b1, 1'b1, "rst_load");
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid_immediate");
    q1.delete(); q4.delete(); q8.delete();
    for (int i = 0; i < 3; i++) last_exp[i] = '0;
    v1 = 1'b0;
    #2;
    rst_n = 1'b1;
    step(0, 8'd0, 8'd0, 1'b0, 1'b0, "rst_idle");
    step(0, 8'd0, 8'd1, 1'b0, 1'b1, "rst_first_valid");
  endtask

  task automatic test_w4();
    step(1, 8'h0F, 8'h0F, 1'b1, 1'b1, "w4_all_ones");
    step(1, 8'h07, 8'h01, 1'b0, 1'b1, "w4_ovf");
    step(1, 8'h00, 8'h00, 1'b0, 1'b1, "w4_zero");
    step(1, 8'h08, 8'h08, 1'b0, 1'b1, "w4_neg_ovf");
    step(1, 8'h05, 8'h03, 1'b1, 1'b0, "w4_idle");
  endtask

  task automatic test_back_to_back_random_w8();
    step(2, 8'hFF, 8'hFF, 1'b1, 1'b1, "w8_all_ones");
    for (int i = 0; i < 1000; i++) begin
      step(2, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), "w8_rand");
    end
    step(2, 8'h00, 8'h00, 1'b0, 1'b0, "w8_drain");
  endtask

  task automatic test_scoreboard_empty();
    checks++;
    if (q1.size() != 0 || q4.size() != 0 || q8.size() != 0) begin
      failures++;
      $display("FAIL sb_empty left=%0d/%0d/%0d exp 0", q1.size(), q4.size(), q8.size());
    end
  endtask

  initial begin
    test_reset();
    test_sequence_w1();
    test_exhaustive_w1();
    test_hold();
    test_reset_midstream();
    test_w4();
    test_back_to_back_random_w8();
    test_scoreboard_empty();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
